// File: rtl/enc_pkg.sv
// Constants shared by the encoder event packetizer (transmit) and unpacketizer (receive).
// Packet: three 32-bit words, little endian, tlast on the state word only.
package enc_pkg;
  localparam int PKT_WORDS = 3;
  localparam int W_CNT_LO  = 0;
  localparam int W_CNT_HI  = 1;
  localparam int W_STATE   = 2;

  typedef enum logic [1:0] {
    ST_W0     = 2'd0,
    ST_W1     = 2'd1,
    ST_W2     = 2'd2,
    ST_RESYNC = 2'd3
  } unpk_state_e;

  // Word 2 carries only the state bit; everything above it must be zero.
  function automatic logic pad_ok(input logic [31:0] w);
    return (w[31:1] == 31'd0);
  endfunction
endpackage

// File: rtl/enc_unpacket_if.sv
// Stream bundle around the unpacketizer: 32-bit word stream in, 64-bit event stream out.
// master = environment side (upstream source + downstream sink), slave = unpacketizer.
interface enc_unpacket_if;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tuser;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tuser, m_axis_tvalid, m_axis_tlast
  );
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tuser, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/enc_unpacket_outreg.sv
// Single-entry output holding register. slot_free tells the FSM a new event may load
// this cycle (empty, or the held event drains on this edge).
module enc_unpacket_outreg (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [63:0] ld_data,
  input  logic        ld_user,
  input  logic        m_tready,
  output logic [63:0] m_tdata,
  output logic        m_tuser,
  output logic        m_tvalid,
  output logic        slot_free
);
  assign slot_free = ~m_tvalid | m_tready;

  always_ff @(posedge clk) begin
    if (reset) begin
      m_tdata  <= '0;
      m_tuser  <= 1'b0;
      m_tvalid <= 1'b0;
    end else if (load) begin
      // A load while draining replaces the event with no bubble.
      m_tdata  <= ld_data;
      m_tuser  <= ld_user;
      m_tvalid <= 1'b1;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end
endmodule

// File: rtl/enc_unpacket.sv
// Encoder event unpacketizer: reassembles three-word packets into {count, state} events,
// drops malformed packets, resynchronises on tlast and counts framing errors.
module enc_unpacket
  import enc_pkg::*;
#(
  parameter bit CHECK_PAD     = 1'b1,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  enc_unpacket_if.slave            bus,
  output logic                     err_frame,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);
  unpk_state_e state;
  logic [31:0] lo_buf, hi_buf;
  logic        slot_free, accept, pad_good, load, err_det;

  assign bus.s_axis_tready = (state == ST_W2) ? slot_free : 1'b1;
  assign bus.m_axis_tlast  = 1'b1;
  assign accept   = bus.s_axis_tvalid & bus.s_axis_tready;
  assign pad_good = !CHECK_PAD || pad_ok(bus.s_axis_tdata);
  assign load     = accept && (state == ST_W2) && bus.s_axis_tlast && pad_good;

  always_comb begin
    err_det = 1'b0;
    case (state)
      ST_W0, ST_W1: err_det = accept && bus.s_axis_tlast;
      ST_W2:        err_det = accept && (!bus.s_axis_tlast || !pad_good);
      default:      err_det = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_W0;
      lo_buf    <= '0;
      hi_buf    <= '0;
      err_frame <= 1'b0;
      err_count <= '0;
    end else begin
      err_frame <= err_det;
      if (err_det && (err_count != '1))
        err_count <= err_count + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
      if (accept) begin
        case (state)
          ST_W0: if (!bus.s_axis_tlast) begin
            lo_buf <= bus.s_axis_tdata;
            state  <= ST_W1;
          end
          ST_W1: if (bus.s_axis_tlast) state <= ST_W0;
          else begin
            hi_buf <= bus.s_axis_tdata;
            state  <= ST_W2;
          end
          // Missing tlast on word 2: skip everything up to the next tlast.
          ST_W2:     state <= bus.s_axis_tlast ? ST_W0 : ST_RESYNC;
          ST_RESYNC: if (bus.s_axis_tlast) state <= ST_W0;
          default:   state <= ST_W0;
        endcase
      end
    end
  end

  enc_unpacket_outreg u_outreg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .ld_data   ({hi_buf, lo_buf}),
    .ld_user   (bus.s_axis_tdata[0]),
    .m_tready  (bus.m_axis_tready),
    .m_tdata   (bus.m_axis_tdata),
    .m_tuser   (bus.m_axis_tuser),
    .m_tvalid  (bus.m_axis_tvalid),
    .slot_free (slot_free)
  );
endmodule

// File: doc/enc_unpacket.md
Name: enc_unpacket

Overview:
- Receive side of the encoder event packet stream: 32-bit AXI-Stream words in, one reassembled 64-bit count plus 1-bit state event out.
- Packet format is three words, little endian:
  - word 0: count[31:0]
  - word 1: count[63:32]
  - word 2: {31'b0, state}, with tlast asserted on this word only
- Sits host-side or loopback-side of the DMA path. Validates framing, resynchronises on errors and counts them.

Parameters:
- CHECK_PAD, 1: when 1, a nonzero word-2 bits[31:1] is a framing error.
- ERR_CNT_WIDTH, 16: width of the saturating error counter.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  32  packet word.
- s_axis_tvalid  in  1  word valid.
- s_axis_tready  out  1  word accepted when tvalid & tready.
- s_axis_tlast  in  1  last word of packet.
- m_axis_tdata  out  64  reassembled count.
- m_axis_tuser  out  1  reassembled state bit.
- m_axis_tvalid  out  1  event valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  constant 1; every output beat is a complete event.
- err_frame  out  1  one-cycle pulse per detected framing error.
- err_count  out  ERR_CNT_WIDTH  saturating count of framing errors.

Behaviour:
- Reset (synchronous, priority over everything):
  - state = W0; assembly buffers cleared.
  - m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tuser = 0.
  - err_frame = 0, err_count = 0.
  - A reset mid-packet discards the partial packet and any pending output event.
- State machine W0, W1, W2, RESYNC. "Accept" means s_axis_tvalid & s_axis_tready.
  - W0: s_axis_tready = 1.
    - Accept with tlast = 0: lo_buf <= tdata; go to W1.
    - Accept with tlast = 1: framing error; stay in W0.
  - W1: s_axis_tready = 1.
    - Accept with tlast = 0: hi_buf <= tdata; go to W2.
    - Accept with tlast = 1: framing error; go to W0.
  - W2: s_axis_tready = ~m_axis_tvalid | m_axis_tready, i.e. the output slot is free or draining this cycle.
    - Accept with tlast = 1 and pad OK: load output register with m_axis_tdata <= {hi_buf, lo_buf} and m_axis_tuser <= tdata[0]; set m_axis_tvalid; go to W0.
    - Accept with tlast = 1 and pad bad (CHECK_PAD = 1, tdata[31:1] != 0): framing error; packet dropped; go to W0.
    - Accept with tlast = 0: framing error; packet dropped; go to RESYNC.
  - RESYNC: s_axis_tready = 1. Discard words. The accepted word with tlast = 1 is also discarded and the FSM returns to W0.
- Output handshake:
  - m_axis_tvalid, once set, holds with tdata and tuser stable until m_axis_tready.
  - Clears on tvalid & tready, unless a new event loads in the same cycle; the new event then replaces it with tvalid kept at 1 and no bubble.
  - Latency: word-2 accept to m_axis_tvalid high is 1 cycle.
  - Sustained rate: one event per 3 input beats.
- Assembly and output registers are separate, so words 0 and 1 of the next packet are accepted while an event is stalled. Only word 2 back-pressures.
- Error reporting:
  - err_frame pulses high exactly 1 cycle, in the cycle after the offending accept.
  - err_count increments by 1 per error and saturates at all-ones, with no wrap.
  - No output event is ever produced from an errored packet.
- No combinational path from m_axis_tready to m_axis_tvalid. A path from m_axis_tready to s_axis_tready exists in W2 only.

Decomposition:
- Shared package enc_pkg:
  - PKT_WORDS = 3.
  - Word-index constants W_CNT_LO = 0, W_CNT_HI = 1, W_STATE = 2.
  - FSM state encoding.
  - These constants are shared with the transmit-side packetizer.
- One sub-module is natural: enc_unpacket_outreg. It is the single-entry output holding register with the valid/ready logic and exposes a "slot free" signal to the FSM.
- The error counter stays inline.

Test Plan:
- Single packet: 0x89ABCDEF, 0x01234567, 0x00000001 (tlast) with m_axis_tready = 1 → one beat, tdata = 0x0123456789ABCDEF, tuser = 1, tlast = 1, err_count = 0.
- Back-pressure: m_axis_tready = 0 for 10 cycles while two packets are sent → first event held stable, second packet's word 2 stalls with s_axis_tready = 0. After release, both events emerge in order with no loss and no duplication.
- Early tlast: tlast on word 1, then a valid packet (count 0x5, state 0) → err_frame pulses once, err_count = 1, only the count 0x5 / state 0 event is output.
- Missing tlast: 5 words with tlast on the 5th, then a valid packet → err_count = 1, 5 words discarded, valid packet output correctly.
- Pad check: word 2 = 0x00000003 with CHECK_PAD = 1 → packet dropped, err_count = 1. With CHECK_PAD = 0 → event output with tuser = 1.
- Reset and saturation:
  - Reset asserted after word 1 → no output; the next full packet decodes correctly.
  - With ERR_CNT_WIDTH = 2, 5 errors → err_count = 3.
